// File: rtl/seq_mul_div_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_div_pkg
// Shared definitions for the iterative multiply/divide unit and the pipeline
// hazard/stall logic that watches it.
//   MD_WIDTH       : default operand width
//   ST_IDLE/RUN/FIN: FSM state encoding (2 bits)
//   OP_MUL/OP_DIV  : operation select encoding
// -----------------------------------------------------------------------------
package seq_mul_div_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/seq_mul_div_addsub.sv
// -----------------------------------------------------------------------------
// seq_mul_div_addsub
// N-bit ripple add/sub block shared with the EX-stage ALU.
//   x, y : operands
//   sel  : 0 = x + y, 1 = x - y (computed as x + ~y + 1)
//   sum  : N-bit result
//   cout : carry out; for subtract, 1 means no borrow (x >= y)
// -----------------------------------------------------------------------------
module seq_mul_div_addsub #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sel,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] y_eff;

  // Conditional invert of y plus carry-in of sel gives two's complement subtract.
  always_comb begin
    y_eff = {N{1'b0}};
    if (sel) begin
      y_eff = ~y;
    end else begin
      y_eff = y;
    end
    {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {{N{1'b0}}, sel};
  end

endmodule

// File: rtl/seq_mul_div.sv
// -----------------------------------------------------------------------------
// seq_mul_div
// Iterative unsigned N x N multiply / N / N restoring divide for the EX stage.
// One pass through the shared add/sub block per cycle, N cycles per operation.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : launch request, honoured only in IDLE
//   op          : 0 = multiply, 1 = divide
//   a, b        : multiplicand/dividend, multiplier/divisor
//   busy        : high while iterating (pipeline stalls on it)
//   done        : one-cycle pulse when hi/lo become valid
//   hi, lo      : mul -> product high/low; div -> remainder/quotient
//   div_by_zero : set with done for a divide by zero, cleared on next start
// -----------------------------------------------------------------------------
module seq_mul_div
  import seq_mul_div_pkg::*;
#(
  parameter int N = MD_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_by_zero
);

  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             op_q;
  logic [N-1:0]     b_q;
  // Working pair: acc/mq for multiply, rem/quo for divide.
  logic [N-1:0]     work_hi;
  logic [N-1:0]     work_lo;

  logic [N-1:0]     add_x;
  logic [N-1:0]     add_y;
  logic             add_sel;
  logic [N-1:0]     add_sum;
  logic             add_cout;

  logic [N-1:0]     div_t;
  logic             div_msb;
  logic [N-1:0]     hi_next;
  logic [N-1:0]     lo_next;

  seq_mul_div_addsub #(.N(N)) u_addsub (
    .x    (add_x),
    .y    (add_y),
    .sel  (add_sel),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Adder operand steering for the current iteration.
  always_comb begin
    div_t   = {work_hi[N-2:0], work_lo[N-1]};
    div_msb = work_hi[N-1];
    add_x   = {N{1'b0}};
    add_y   = {N{1'b0}};
    add_sel = 1'b0;
    if (op_q == OP_DIV) begin
      add_x   = div_t;
      add_y   = b_q;
      add_sel = 1'b1;
    end else begin
      add_x   = work_hi;
      add_sel = 1'b0;
      if (work_lo[0]) begin
        add_y = b_q;
      end else begin
        add_y = {N{1'b0}};
      end
    end
  end

  // Next working-register values after one iteration.
  always_comb begin
    hi_next = work_hi;
    lo_next = work_lo;
    if (op_q == OP_DIV) begin
      // The bit shifted out of rem (msb) makes t >= 2^N > b even if the
      // N-bit subtract reports a borrow, so it forces the restore to be skipped.
      if (div_msb || add_cout) begin
        hi_next = add_sum;
        lo_next = {work_lo[N-2:0], 1'b1};
      end else begin
        hi_next = div_t;
        lo_next = {work_lo[N-2:0], 1'b0};
      end
    end else begin
      {hi_next, lo_next} = {add_cout, add_sum, work_lo[N-1:1]};
    end
  end

  // Control FSM, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= {CNT_W{1'b0}};
      op_q        <= OP_MUL;
      b_q         <= {N{1'b0}};
      work_hi     <= {N{1'b0}};
      work_lo     <= {N{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= {N{1'b0}};
      lo          <= {N{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q        <= op;
            b_q         <= b;
            work_hi     <= {N{1'b0}};
            work_lo     <= a;
            cnt         <= {CNT_W{1'b0}};
            div_by_zero <= 1'b0;
            if ((op == OP_DIV) && (b == {N{1'b0}})) begin
              state       <= ST_FIN;
              busy        <= 1'b0;
              done        <= 1'b1;
              hi          <= a;
              lo          <= {N{1'b1}};
              div_by_zero <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          work_hi <= hi_next;
          work_lo <= lo_next;
          cnt     <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt == LAST_ITER) begin
            // Results go straight from the final iteration into hi/lo.
            state <= ST_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= hi_next;
            lo    <= lo_next;
          end else begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_div.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_div
// Directed self-checking bench for seq_mul_div (N = 32).
// Cycle 0 is the cycle in which start is high; outputs are sampled on the
// falling edge, so "cycle k" is the k-th falling edge after the accepting edge.
// -----------------------------------------------------------------------------
module tb_seq_mul_div;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic         div_by_zero;

  int checks;
  int errors;

  seq_mul_div #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one start pulse that the rising edge will sample.
  task automatic launch(input logic op_i, input logic [N-1:0] a_i, input logic [N-1:0] b_i);
    @(negedge clk);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; report its cycle (-1 on timeout) and busy cycles seen.
  task automatic wait_done(input int first, input int budget, output int done_cyc, output int busy_cnt);
    done_cyc = -1;
    busy_cnt = 0;
    for (int c = first; (c < first + budget) && (done_cyc < 0); c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cyc = c;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero, hi, lo} !== {3'b000, 64'h0}) begin
      errors++;
      $display("FAIL reset_state: busy=%0b done=%0b dbz=%0b hi=%h lo=%h, required all zero",
               busy, done, div_by_zero, hi, lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul;
    logic [N-1:0] ta [3];
    logic [N-1:0] tb [3];
    logic [N-1:0] eh [3];
    logic [N-1:0] el [3];
    int dc;
    int bc;
    ta[0] = 32'd7;         tb[0] = 32'd6;         eh[0] = 32'h0;         el[0] = 32'h2A;
    ta[1] = 32'hFFFFFFFF;  tb[1] = 32'hFFFFFFFF;  eh[1] = 32'hFFFFFFFE;  el[1] = 32'h1;
    ta[2] = 32'h80000000;  tb[2] = 32'd2;         eh[2] = 32'h1;         el[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      launch(1'b0, ta[i], tb[i]);
      wait_done(1, 60, dc, bc);
      checks++;
      if (dc !== 33 || bc !== 32 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mul_timing[%0d]: done_cycle=%0d busy_cycles=%0d busy_at_done=%0b, required 33/32/0",
                 i, dc, bc, busy);
      end
      checks++;
      if (hi !== eh[i] || lo !== el[i] || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL mul_result[%0d]: hi=%h lo=%h dbz=%0b, required hi=%h lo=%h dbz=0",
                 i, hi, lo, div_by_zero, eh[i], el[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL mul_done_pulse[%0d]: done=%0b one cycle after done, required 0", i, done);
      end
    end
  endtask

  task automatic test_div;
    logic [N-1:0] ta [3];
    logic [N-1:0] tb [3];
    logic [N-1:0] eh [3];
    logic [N-1:0] el [3];
    int dc;
    int bc;
    ta[0] = 32'd100;       tb[0] = 32'd7;  eh[0] = 32'd2;  el[0] = 32'd14;
    ta[1] = 32'hFFFFFFFF;  tb[1] = 32'd1;  eh[1] = 32'd0;  el[1] = 32'hFFFFFFFF;
    ta[2] = 32'd5;         tb[2] = 32'd9;  eh[2] = 32'd5;  el[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      launch(1'b1, ta[i], tb[i]);
      wait_done(1, 60, dc, bc);
      checks++;
      if (dc !== 33 || bc !== 32) begin
        errors++;
        $display("FAIL div_timing[%0d]: done_cycle=%0d busy_cycles=%0d, required 33/32", i, dc, bc);
      end
      checks++;
      if (hi !== eh[i] || lo !== el[i] || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL div_result[%0d]: hi=%h lo=%h dbz=%0b, required hi=%h lo=%h dbz=0",
                 i, hi, lo, div_by_zero, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_div_by_zero;
    int dc;
    int bc;
    launch(1'b1, 32'h1234, 32'h0);
    wait_done(1, 40, dc, bc);
    checks++;
    if (dc !== 1 || bc !== 0) begin
      errors++;
      $display("FAIL dbz_timing: done_cycle=%0d busy_cycles=%0d, required 1/0", dc, bc);
    end
    checks++;
    if (hi !== 32'h1234 || lo !== 32'hFFFFFFFF || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result: hi=%h lo=%h dbz=%0b, required hi=00001234 lo=ffffffff dbz=1",
               hi, lo, div_by_zero);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (div_by_zero !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL dbz_hold: dbz=%0b done=%0b in idle, required dbz=1 done=0", div_by_zero, done);
    end
    launch(1'b1, 32'd100, 32'd7);
    @(negedge clk);
    checks++;
    if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dbz_clear: dbz=%0b busy=%0b at cycle 1, required dbz=0 busy=1", div_by_zero, busy);
    end
    wait_done(2, 60, dc, bc);
    checks++;
    if (dc !== 33 || hi !== 32'd2 || lo !== 32'd14) begin
      errors++;
      $display("FAIL dbz_followup: done_cycle=%0d hi=%h lo=%h, required 33 hi=2 lo=14", dc, hi, lo);
    end
  endtask

  task automatic test_busy_start;
    int dc;
    int bc;
    logic ok;
    launch(1'b0, 32'd7, 32'd6);
    dc = -1;
    bc = 0;
    ok = 1'b1;
    for (int c = 1; (c < 60) && (dc < 0); c++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) dc = c;
      if (c == 9) begin
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd100;
        b     = 32'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checks++;
    if (dc !== 33 || bc !== 32) begin
      errors++;
      $display("FAIL busy_start_timing: done_cycle=%0d busy_cycles=%0d, required 33/32", dc, bc);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h2A || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_result: hi=%h lo=%h dbz=%0b, required hi=0 lo=2a dbz=0",
               hi, lo, div_by_zero);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (hi !== 32'h0 || lo !== 32'h2A || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL idle_hold: hi=%h lo=%h busy=%0b done=%0b, required stable 0/2a/0/0",
               hi, lo, busy, done);
    end
  endtask

  task automatic test_reset_mid_op;
    int dc;
    int bc;
    logic saw_activity;
    launch(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero, hi, lo} !== {3'b000, 64'h0}) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%0b done=%0b dbz=%0b hi=%h lo=%h, required all zero",
               busy, done, div_by_zero, hi, lo);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_activity = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || busy) saw_activity = 1'b1;
    end
    checks++;
    if (saw_activity !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: busy/done activity=%0b after abort, required 0", saw_activity);
    end
    launch(1'b0, 32'd7, 32'd6);
    wait_done(1, 60, dc, bc);
    checks++;
    if (dc !== 33 || bc !== 32 || hi !== 32'h0 || lo !== 32'h2A) begin
      errors++;
      $display("FAIL reset_recover: done_cycle=%0d busy_cycles=%0d hi=%h lo=%h, required 33/32/0/2a",
               dc, bc, hi, lo);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_busy_start();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mul_div.md
Name: seq_mul_div

Overview:
Iterative unsigned 32x32 multiply / 32/32 divide unit in the EX stage, alongside the add/sub ALU.
- Consumes the ripple add/sub datapath: one add (multiply) or one subtract (divide) per cycle.
- Produces a 64-bit {hi, lo} result for the EX/MEM register via a start/busy/done handshake.
- The pipeline stalls on busy.

Parameters:
N, 32, operand width; iteration count equals N.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  launch operation; sampled only in IDLE
op  in  1  0 = multiply, 1 = divide
a  in  N  multiplicand / dividend
b  in  N  multiplier / divisor
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse; hi/lo valid from this cycle on
hi  out  N  mul: product[2N-1:N]; div: remainder
lo  out  N  mul: product[N-1:0]; div: quotient
div_by_zero  out  1  set with done when op=1 and b==0; cleared on next accepted start

Behaviour:
Reset (rst_n low, async): state=IDLE; busy=0, done=0, hi=0, lo=0, div_by_zero=0; iteration counter=0; operand registers=0.

Reset mid-operation: aborts immediately. No done pulse. Outputs return to reset values.

FSM states: IDLE, RUN, FIN.
- IDLE, start=1: latch a, b, op.
  - op=1 with b==0: go to FIN, hi=a, lo={N{1}}, div_by_zero=1.
  - Otherwise: go to RUN, counter=0.
- IDLE, start=0: stay.
- RUN: one iteration per cycle. counter++. After iteration N-1, go to FIN.
- FIN: done=1 for exactly this cycle, busy=0; next state IDLE.
- start while busy (RUN/FIN): ignored; no queuing.

Latency:
- Normal: start at cycle 0; busy high cycles 1..N; done at cycle N+1.
- Divide by zero: done at cycle 1.
- hi/lo/div_by_zero hold until the next accepted start.
- hi/lo are not updated during RUN. Internal working registers are separate from the output registers.

Multiply iteration (working regs acc[N], mq[N], mq initialised to a, acc to 0):
- Adder computes acc + (mq[0] ? b : 0), cin=0, producing N-bit sum + cout.
- Shift right: {acc, mq} <= {cout, sum, mq[N-1:1]}.
- Result: hi=acc, lo=mq.

Divide iteration (restoring; rem[N], quo[N] initialised to 0 and a):
- Shift left: t = {rem[N-2:0], quo[N-1]}, with msb = rem[N-1].
- Adder computes t - b (sel=1, i.e. t + ~b + 1).
- If msb=1 or cout=1 (no borrow): rem<=diff, quo<={quo[N-2:0],1}.
- Else: rem<=t, quo<={quo[N-2:0],0}.
- Result: hi=rem, lo=quo.

Arithmetic: unsigned only. All operations use exactly one N-bit add/sub per cycle; there is no wider adder.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, FIN=2'd2) and op encoding (OP_MUL=1'b0, OP_DIV=1'b1). Both are reused by the hazard/stall unit.
- Sub-module: instantiate the existing 32-bit add/sub block as the sole datapath adder.
  - sel=0 for multiply; sel=1 for divide.
  - The b-input mux (0/b) is local.
- Counter width: clog2(N)+1.

Test Plan:
- Multiply: op=0, a=7, b=6, start -> busy cycles 1..32, done at cycle 33, hi=0x00000000, lo=0x0000002A.
- Multiply: op=0, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Also a=0x80000000, b=2 -> hi=1, lo=0.
- Divide: op=1, a=100, b=7 -> lo=14, hi=2, div_by_zero=0. Also a=0xFFFFFFFF, b=1 -> lo=0xFFFFFFFF, hi=0. Also a=5, b=9 -> lo=0, hi=5.
- Divide by zero: op=1, a=0x1234, b=0 -> done at cycle 1, hi=0x1234, lo=0xFFFFFFFF, div_by_zero=1. Next accepted start clears the flag.
- Start while busy: second start with different operands at cycle 10 -> ignored; first result delivered at cycle 33; hi/lo stable until the next start from IDLE.
- Reset mid-op: rst_n low at cycle 15 (asynchronous, between edges) -> busy/hi/lo/done 0 immediately; no done pulse. A new start after release completes normally.
